// File: rtl/dht_responder.sv
// DHT11-style single-wire responder: detects a host start pulse and answers with
// the response preamble and a 40-bit {humidity, temperature, checksum} frame.
module dht_responder #(
   parameter int CLK_FREQ_MHZ = 100,
   parameter int START_MIN_US = 18000,
   parameter int RESP_DLY_US  = 30,
   parameter int RESP_LOW_US  = 80,
   parameter int RESP_HIGH_US = 80,
   parameter int BIT_LOW_US   = 50,
   parameter int BIT0_HIGH_US = 26,
   parameter int BIT1_HIGH_US = 70
)(
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iEnable,
   input  logic [7:0] iHumid_Int,
   input  logic [7:0] iHumid_Dec,
   input  logic [7:0] iTemp_Int,
   input  logic [7:0] iTemp_Dec,
   inout  wire        ioDHT,
   output logic       oBusy,
   output logic       oDone,
   output logic [3:0] oState
);

   function automatic int fmax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int US_MAX = fmax(fmax(fmax(START_MIN_US, RESP_DLY_US), fmax(RESP_LOW_US, RESP_HIGH_US)),
                                fmax(BIT_LOW_US, fmax(BIT0_HIGH_US, BIT1_HIGH_US)));
   localparam int US_W   = $clog2(US_MAX + 1);
   localparam int DIV_W  = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_START_LOW = 4'd1,
      S_WAIT_REL  = 4'd2,
      S_RESP_DLY  = 4'd3,
      S_RESP_LOW  = 4'd4,
      S_RESP_HIGH = 4'd5,
      S_BIT_LOW   = 4'd6,
      S_BIT_HIGH  = 4'd7,
      S_END_LOW   = 4'd8
   } state_t;

   state_t             r_state;
   logic [2:0]         r_sync;
   logic [DIV_W-1:0]   r_div;
   logic [US_W-1:0]    r_us;
   logic [5:0]         r_bit;
   logic [39:0]        r_shift;
   logic               r_done;

   logic               w_fall, w_rise, w_tick, w_phase_end, w_drive;
   logic [7:0]         w_sum;
   int                 w_target;

   // [0] first stage, [1] synced line, [2] previous synced value for edge detection
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) r_sync <= 3'b111;
      else      r_sync <= {r_sync[1:0], ioDHT};
   end

   assign w_fall = r_sync[2] & ~r_sync[1];
   assign w_rise = ~r_sync[2] & r_sync[1];
   assign w_tick = (r_div == DIV_W'(CLK_FREQ_MHZ - 1));
   assign w_sum  = iHumid_Int + iHumid_Dec + iTemp_Int + iTemp_Dec;

   always_comb begin
      w_target = 1;
      case (r_state)
         S_START_LOW: w_target = START_MIN_US;
         S_RESP_DLY:  w_target = RESP_DLY_US;
         S_RESP_LOW:  w_target = RESP_LOW_US;
         S_RESP_HIGH: w_target = RESP_HIGH_US;
         S_BIT_LOW:   w_target = BIT_LOW_US;
         S_BIT_HIGH:  w_target = r_shift[39] ? BIT1_HIGH_US : BIT0_HIGH_US;
         S_END_LOW:   w_target = BIT_LOW_US;
         default:     w_target = 1;
      endcase
   end

   assign w_phase_end = w_tick && (r_us == US_W'(w_target - 1));

   // Every state entry clears the divider and us counter so each phase is exact.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_us    <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_tick) begin
            r_div <= '0;
            r_us  <= r_us + 1'b1;
         end else begin
            r_div <= r_div + 1'b1;
         end
         case (r_state)
            S_IDLE: if (w_fall && iEnable) begin
               r_state <= S_START_LOW; r_div <= '0; r_us <= '0;
            end
            S_START_LOW: begin
               if (r_sync[1]) begin
                  r_state <= S_IDLE; r_div <= '0; r_us <= '0;
               end else if (w_phase_end) begin
                  r_state <= S_WAIT_REL; r_div <= '0; r_us <= '0;
               end
            end
            S_WAIT_REL: if (w_rise) begin
               r_state <= S_RESP_DLY; r_div <= '0; r_us <= '0;
            end
            S_RESP_DLY: if (w_phase_end) begin
               r_state <= S_RESP_LOW; r_div <= '0; r_us <= '0;
               r_shift <= {iHumid_Int, iHumid_Dec, iTemp_Int, iTemp_Dec, w_sum};
               r_bit   <= '0;
            end
            S_RESP_LOW: if (w_phase_end) begin
               r_state <= S_RESP_HIGH; r_div <= '0; r_us <= '0;
            end
            S_RESP_HIGH: if (w_phase_end) begin
               r_state <= S_BIT_LOW; r_div <= '0; r_us <= '0;
            end
            S_BIT_LOW: if (w_phase_end) begin
               r_state <= S_BIT_HIGH; r_div <= '0; r_us <= '0;
            end
            S_BIT_HIGH: if (w_phase_end) begin
               r_shift <= {r_shift[38:0], 1'b0};
               r_div   <= '0; r_us <= '0;
               if (r_bit == 6'd39) begin
                  r_state <= S_END_LOW;
               end else begin
                  r_state <= S_BIT_LOW;
                  r_bit   <= r_bit + 1'b1;
               end
            end
            S_END_LOW: if (w_phase_end) begin
               r_state <= S_IDLE; r_div <= '0; r_us <= '0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE; r_div <= '0; r_us <= '0;
            end
         endcase
      end
   end

   // Drive decodes straight from the state register so reset releases the line at once.
   assign w_drive = (r_state == S_RESP_LOW) || (r_state == S_BIT_LOW) || (r_state == S_END_LOW);
   assign ioDHT   = w_drive ? 1'b0 : 1'bz;
   assign oBusy   = (r_state >= S_RESP_DLY) && (r_state <= S_END_LOW);
   assign oDone   = r_done;
   assign oState  = r_state;

endmodule

// File: tb/tb_dht_responder.sv
// Host-side bench for dht_responder: issues start pulses, times the line and decodes frames.
module tb_dht_responder;
   localparam int F    = 3;
   localparam int SMIN = 100;

   logic       clk = 1'b0, rst = 1'b1, en = 1'b1, host_low = 1'b0;
   logic [7:0] hi_, hd, ti, td;
   logic       busy, done;
   logic [3:0] st;
   wire        dht;
   int         n_cmp = 0, n_bad = 0;

   assign dht = host_low ? 1'b0 : 1'bz;
   pullup (dht);
   always #5 clk = ~clk;

   dht_responder #(.CLK_FREQ_MHZ(F), .START_MIN_US(SMIN)) dut (
      .iClk(clk), .iRst(rst), .iEnable(en),
      .iHumid_Int(hi_), .iHumid_Dec(hd), .iTemp_Int(ti), .iTemp_Dec(td),
      .ioDHT(dht), .oBusy(busy), .oDone(done), .oState(st)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] model(input logic [7:0] a, b, c, d);
      int s;
      s = int'(a) + int'(b) + int'(c) + int'(d);
      return {a, b, c, d, 8'(s % 256)};
   endfunction

   task automatic wait_lvl(input logic lvl, output int cnt, output bit ok);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (dht !== lvl && cnt < 400 * F);
      ok = (dht === lvl);
      chk("wait_line", dht, lvl);
   endtask

   task automatic quiet(input string tag, input int us);
      int lows, busys;
      lows = 0; busys = 0;
      repeat (us * F) begin
         @(negedge clk);
         if (dht !== 1'b1) lows++;
         if (busy) busys++;
      end
      chk({tag, "_line"}, lows, 0);
      chk({tag, "_busy"}, busys, 0);
      chk({tag, "_state"}, st, 0);
   endtask

   task automatic host_pulse(input int us);
      @(negedge clk);
      host_low = 1'b1;
      repeat (us * F) @(negedge clk);
      host_low = 1'b0;
   endtask

   // act: 1 = change temp int, 2 = drop enable, 3 = async reset; applied at start of bit act_bit low
   task automatic run_frame(input int low_us, input int act, input int act_bit);
      logic [39:0] exp, got;
      int          c, terr;
      bit          ok, b;
      exp = model(hi_, hd, ti, td);
      got = '0; terr = 0;
      @(negedge clk);
      host_low = 1'b1;
      repeat (low_us * F) @(negedge clk);
      chk("wait_rel_state", st, 2);
      chk("wait_rel_busy", busy, 0);
      host_low = 1'b0;
      wait_lvl(1'b0, c, ok); if (!ok) return;
      chk("resp_dly_err", ((c >= 29 * F) && (c <= 31 * F)) ? 0 : c, 0);
      chk("busy_frame", busy, 1);
      wait_lvl(1'b1, c, ok); if (!ok) return;
      chk("resp_low", c, 80 * F);
      wait_lvl(1'b0, c, ok); if (!ok) return;
      chk("resp_high", c, 80 * F);
      for (int i = 0; i < 40; i++) begin
         if (i == act_bit) begin
            case (act)
               1: ti = 8'h42;
               2: en = 1'b0;
               3: begin
                  rst = 1'b1;
                  #1;
                  chk("rst_mid_line", dht, 1);
                  chk("rst_mid_state", st, 0);
                  chk("rst_mid_busy", busy, 0);
                  @(negedge clk);
                  rst = 1'b0;
                  return;
               end
               default: ;
            endcase
         end
         wait_lvl(1'b1, c, ok); if (!ok) return;
         if (c != 50 * F) terr++;
         wait_lvl(1'b0, c, ok); if (!ok) return;
         b = (c > 48 * F);
         got = {got[38:0], b};
         if (c != (exp[39 - i] ? 70 * F : 26 * F)) terr++;
      end
      wait_lvl(1'b1, c, ok); if (!ok) return;
      chk("end_low", c, 50 * F);
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      @(negedge clk);
      chk("done_clear", done, 0);
      for (int k = 0; k < 5; k++)
         chk($sformatf("byte%0d", k), got[39 - 8 * k -: 8], exp[39 - 8 * k -: 8]);
      chk("bit_timing_errs", terr, 0);
   endtask

   task automatic rand_bytes();
      hi_ = 8'($urandom); hd = 8'($urandom); ti = 8'($urandom); td = 8'($urandom);
   endtask

   initial begin
      hi_ = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h05;
      repeat (5) @(negedge clk);
      chk("rst_line", dht, 1);
      chk("rst_state", st, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      repeat (20 * F) @(negedge clk);

      // reference frame 37 00 19 05 55, temp int changes mid-frame
      run_frame(150, 1, 3);
      repeat (20 * F) @(negedge clk);

      // checksum wrap; enable dropped mid-frame must not cut the frame
      hi_ = 8'hFF; hd = 8'hFF; ti = 8'h01; td = 8'h02;
      run_frame(150, 2, 20);
      en = 1'b1;
      repeat (20 * F) @(negedge clk);

      host_pulse(50);
      quiet("glitch", 150);

      rand_bytes();
      run_frame(110 + int'($urandom_range(0, 90)), 3, 12);
      repeat (20 * F) @(negedge clk);

      rand_bytes();
      run_frame(110 + int'($urandom_range(0, 90)), 0, -1);
      repeat (20 * F) @(negedge clk);

      en = 1'b0;
      host_pulse(150);
      quiet("disabled", 300);
      en = 1'b1;
      rand_bytes();
      run_frame(150, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dht_responder.md
Name: dht_responder

Overview:
- Single-wire DHT11 device emulator: the responder end of the host start/response/40-bit protocol used by the DHT sensor path.
- Detects a host start pulse on ioDHT, then drives the standard response and a 5-byte frame: humidity int/dec, temperature int/dec, checksum.
- Used as an on-board loopback target and simulation partner for the DHT host, alongside the Basys3 sensor/clock top.
- Line is open-drain: the block only ever drives 0 or releases to Z.

Parameters:
- CLK_FREQ_MHZ, 100, system clock in MHz; sets the 1 us tick divider.
- START_MIN_US, 18000, minimum host low time accepted as a start (sim override 100).
- RESP_DLY_US, 30, delay from host release to response low.
- RESP_LOW_US, 80, response low phase.
- RESP_HIGH_US, 80, response released phase.
- BIT_LOW_US, 50, low preamble per bit and end-of-frame low.
- BIT0_HIGH_US, 26, released time encoding 0.
- BIT1_HIGH_US, 70, released time encoding 1.

Ports:
- iClk  input  1  system clock.
- iRst  input  1  asynchronous reset, active-high.
- iEnable  input  1  1 = respond to starts; 0 = ignore new starts.
- iHumid_Int  input  8  humidity integer byte.
- iHumid_Dec  input  8  humidity decimal byte.
- iTemp_Int  input  8  temperature integer byte.
- iTemp_Dec  input  8  temperature decimal byte.
- ioDHT  inout  1  open-drain data line: drives 0 when pulling, Z otherwise.
- oBusy  output  1  high from RESP_DLY through END_LOW.
- oDone  output  1  1-cycle pulse on frame completion.
- oState  output  4  current FSM state code (debug).

Behaviour:
- Reset (async): ioDHT = Z; oBusy = 0, oDone = 0, oState = IDLE (0); us counter, bit counter and shift register cleared. Line release takes effect immediately, including mid-frame.
- ioDHT input passes through a 2-FF synchronizer; all edge detection uses the synced value. Fixed 2-cycle input latency.
- us tick: a divider counting 0..CLK_FREQ_MHZ-1 pulses once per microsecond. The divider is cleared on every state entry, so phase durations are exact to within one clock cycle.
- State codes: IDLE = 0, START_LOW = 1, WAIT_REL = 2, RESP_DLY = 3, RESP_LOW = 4, RESP_HIGH = 5, BIT_LOW = 6, BIT_HIGH = 7, END_LOW = 8.
- IDLE: line released. A synced falling edge with iEnable = 1 enters START_LOW and clears the us counter. A falling edge with iEnable = 0 is ignored.
- START_LOW: count us while the line is low.
  - Line rises before START_MIN_US: treat as a glitch, return to IDLE.
  - Counter reaches START_MIN_US: saturate and go to WAIT_REL.
- WAIT_REL: wait for the synced rising edge (host release), then enter RESP_DLY. No timeout; the host may hold the line low indefinitely.
- RESP_DLY: released for RESP_DLY_US. On exit, snapshot the four input bytes into a 40-bit shift register: {H_int, H_dec, T_int, T_dec, checksum}.
- Checksum = (H_int + H_dec + T_int + T_dec) mod 256, computed as an 8-bit truncated sum.
- Input changes after the snapshot do not affect the frame in flight.
- RESP_LOW: drive 0 for RESP_LOW_US. RESP_HIGH: release for RESP_HIGH_US.
- BIT_LOW: drive 0 for BIT_LOW_US.
- BIT_HIGH: release for BIT1_HIGH_US if the current MSB is 1, else BIT0_HIGH_US. Then shift left and increment the bit counter (0..39).
- After bit 39 (counter = 39 at exit), go to END_LOW; otherwise go to BIT_LOW.
- Bit order: MSB first, byte order as listed in the snapshot.
- END_LOW: drive 0 for BIT_LOW_US, then release, pulse oDone for 1 cycle, return to IDLE.
- iEnable deasserted mid-frame: the current frame completes; only new starts are blocked.
- Line activity during RESP_DLY..END_LOW is not monitored (no contention detection).
- The block's own falling edges never trigger a start: starts are only sampled in IDLE, which is entered only after the line is released.
- Back-to-back starts: the next start is accepted on the first falling edge seen in IDLE.

Test Plan:
- START_MIN_US = 100; inputs 0x37, 0x00, 0x19, 0x05; host low 150 us then release -> low begins 30 us ±1 after release, 80 us low, 80 us Z; bytes 37 00 19 05 55; bit highs 26/70 us; oDone pulses once; oBusy spans the frame.
- Host low 50 us (< START_MIN_US) -> line stays Z, oBusy = 0, state returns to IDLE after release.
- Inputs 0xFF, 0xFF, 0x01, 0x02 -> checksum byte 0x01 (0x201 truncated).
- Change iTemp_Int 0x19 -> 0x42 during bit 3 -> transmitted temp byte = 0x19, checksum = 0x55.
- Assert iRst during BIT_LOW of bit 12 -> ioDHT = Z in the same cycle, oState = 0, oBusy = 0; after reset release, a new start yields a correct full frame.
- iEnable = 0, valid 150 us start -> no response; set iEnable = 1 and repeat -> normal frame.
